msg_validity_checker: RTL and testbench

- Task3 stage of the RC4 key-search pipeline. Sits directly downstream of the Task2b decrypt stage and under the FSM_Controller's start/finish protocol.
- Once Task2b has finished writing the decrypted message RAM, the controller asserts start_Task3. The block then reads the message byte by byte and checks that every byte is lowercase ASCII (a-z) or space.
- It reports key_found_Task3 together with finish_Task3. The controller uses this result to stop the search or advance current_key.

---
 rtl/msg_validity_checker.sv | 157 +++++++++++++++
 tb/tb_msg_validity_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/msg_validity_checker.sv
// -----------------------------------------------------------------------------
// msg_validity_checker
//
// Purpose:
//   Stage that checks a decrypted message in RAM for plausibility. When the
//   controller requests a check, the block reads MSG_LEN bytes from a
//   synchronous-read RAM one at a time. It accepts the message only if every
//   byte is lowercase ASCII ('a'..'z') or a space. The check stops at the
//   first bad byte and records that byte's index.
//
// Ports:
//   clk             - system clock, all state changes on the rising edge
//   reset           - asynchronous active-low reset
//   start_Task3     - level request from the controller
//   finish_Task3    - registered completion flag, high for the whole DONE state
//   key_found_Task3 - 1 when all MSG_LEN bytes were valid; meaningful while
//                     finish_Task3 is high, and retained until the next start
//   rd_addr         - registered read address to the decrypted-message RAM
//   rd_data         - RAM read data, valid one clock after rd_addr is sampled
//   fail_index      - index of the first invalid byte, 0 on success
//   dbg_state       - current FSM state encoding for observation
//
// Handshake (four-phase, level based):
//   1. The controller raises start_Task3. The block accepts it only in IDLE.
//   2. The block ignores start_Task3 during FETCH/WAIT/CHECK. Dropping it
//      mid-check does not abort the check.
//   3. In DONE the block holds finish_Task3 = 1 and stable results for as
//      long as start_Task3 stays high. It never restarts from DONE.
//   4. When start_Task3 is low in DONE, the block returns to IDLE and clears
//      finish_Task3 on the same edge. The results stay visible.
//
// Constraint: 2**ADDR_W must be >= MSG_LEN.
// -----------------------------------------------------------------------------
module msg_validity_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_Task3,
  output logic              finish_Task3,
  output logic              key_found_Task3,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] fail_index,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] idx_q,       idx_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic              finish_q,    finish_d;
  logic              key_found_q, key_found_d;
  logic [ADDR_W-1:0] fail_idx_q,  fail_idx_d;

  logic              byte_valid;
  logic [ADDR_W-1:0] idx_next;

  // A byte passes if it is in 'a'..'z' or if it is a space.
  assign byte_valid = ((rd_data >= 8'h61) && (rd_data <= 8'h7A)) ||
                      (rd_data == 8'h20);

  // The index increments only when it is below LAST_IDX, so it cannot wrap.
  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    finish_d    = finish_q;
    key_found_d = key_found_q;
    fail_idx_d  = fail_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_Task3) begin
          idx_d       = '0;
          rd_addr_d   = '0;
          key_found_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      // The RAM samples rd_addr at the end of this cycle.
      S_FETCH: state_d = S_WAIT;

      // Read latency. rd_data shows byte[idx] in the next cycle.
      S_WAIT:  state_d = S_CHECK;

      S_CHECK: begin
        if (!byte_valid) begin
          key_found_d = 1'b0;
          fail_idx_d  = idx_q;
          finish_d    = 1'b1;
          state_d     = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          key_found_d = 1'b1;
          fail_idx_d  = '0;
          finish_d    = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d     = idx_next;
          rd_addr_d = idx_next;
          state_d   = S_FETCH;
        end
      end

      S_DONE: begin
        // Results stay as they are. Leave only after start has dropped.
        if (!start_Task3) begin
          finish_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        finish_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      finish_q    <= 1'b0;
      key_found_q <= 1'b0;
      fail_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      finish_q    <= finish_d;
      key_found_q <= key_found_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign finish_Task3    = finish_q;
  assign key_found_Task3 = key_found_q;
  assign rd_addr         = rd_addr_q;
  assign fail_index      = fail_idx_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_msg_validity_checker.sv
module tb_msg_validity_checker;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int BUDGET  = 200;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_Task3 = 1'b0;
  logic              finish_Task3;
  logic              key_found_Task3;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] fail_index;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  msg_validity_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_Task3     (start_Task3),
    .finish_Task3    (finish_Task3),
    .key_found_Task3 (key_found_Task3),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .fail_index      (fail_index),
    .dbg_state       (dbg_state)
  );

  // Synchronous-read RAM model: data appears one clock after the address is sampled.
  logic [7:0] mem [MSG_LEN];
  always_ff @(posedge clk) rd_data <= mem[rd_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Valid base message: 'a'..'z' followed by a space, repeating.
  task automatic load_msg(input int pos, input logic [7:0] val);
    for (int i = 0; i < MSG_LEN; i++)
      mem[i] = ((i % 27) == 26) ? 8'h20 : 8'(8'h61 + (i % 27));
    if (pos < MSG_LEN) mem[pos] = val;
  endtask

  // Runs one check and compares the results. If pre_started is set, the
  // caller has already raised start at a negedge. The task then holds start
  // for hold extra cycles and performs the release phase.
  task automatic run_check(input string tag, input bit pre_started,
                           input logic exp_found, input logic [ADDR_W-1:0] exp_fail,
                           input int exp_edge, input int hold);
    int edge_n;
    bit got;
    bit addr_bad;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] last_addr;
    exp_q.delete();
    for (int n = 0; n < exp_edge; n++) exp_q.push_back(ADDR_W'(n / 3));
    last_addr = exp_q[exp_q.size() - 1];
    if (!pre_started) begin
      @(negedge clk);
      start_Task3 = 1'b1;
    end
    @(posedge clk);  // edge 0: acceptance
    edge_n = 0;
    got = 0;
    addr_bad = 0;
    while (edge_n < BUDGET) begin
      @(negedge clk);
      if (finish_Task3) begin
        got = 1;
        break;
      end
      if (exp_q.size() == 0) addr_bad = 1;
      else begin
        a = exp_q.pop_front();
        if (rd_addr !== a) addr_bad = 1;
      end
      @(posedge clk);
      edge_n++;
    end
    check({tag, " finish_seen"}, 32'(got), 32'd1);
    check({tag, " finish_edge"}, 32'(edge_n), 32'(exp_edge));
    check({tag, " key_found"}, 32'(key_found_Task3), 32'(exp_found));
    check({tag, " fail_index"}, 32'(fail_index), 32'(exp_fail));
    check({tag, " rd_addr_seq"}, 32'(addr_bad || exp_q.size() != 0), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold_finish"}, 32'(finish_Task3), 32'd1);
      check({tag, " hold_rd_addr"}, 32'(rd_addr), 32'(last_addr));
      check({tag, " hold_state"}, 32'(dbg_state), 32'(ST_DONE));
    end
    start_Task3 = 1'b0;
    @(negedge clk);
    check({tag, " release_finish"}, 32'(finish_Task3), 32'd0);
    check({tag, " release_key_found"}, 32'(key_found_Task3), 32'(exp_found));
    check({tag, " release_fail_index"}, 32'(fail_index), 32'(exp_fail));
    check({tag, " release_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                pos;   // MSG_LEN means no injected byte
    logic [7:0]        val;
    logic              found;
    logic [ADDR_W-1:0] fidx;
    int                fedge;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{32, 8'h00, 1'b1, 5'd0,  96};  // clean message
    vecs[1]  = '{0,  8'h41, 1'b0, 5'd0,  3};   // 'A' at byte 0
    vecs[2]  = '{31, 8'h7B, 1'b0, 5'd31, 96};  // '{' in the last byte
    vecs[3]  = '{5,  8'h60, 1'b0, 5'd5,  18};
    vecs[4]  = '{5,  8'h7B, 1'b0, 5'd5,  18};
    vecs[5]  = '{5,  8'h1F, 1'b0, 5'd5,  18};
    vecs[6]  = '{5,  8'h21, 1'b0, 5'd5,  18};
    vecs[7]  = '{5,  8'hFF, 1'b0, 5'd5,  18};
    vecs[8]  = '{5,  8'h61, 1'b1, 5'd0,  96};
    vecs[9]  = '{5,  8'h7A, 1'b1, 5'd0,  96};
    vecs[10] = '{5,  8'h20, 1'b1, 5'd0,  96};

    load_msg(MSG_LEN, 8'h00);

    // Reset state
    #12;
    check("reset finish", 32'(finish_Task3), 32'd0);
    check("reset key_found", 32'(key_found_Task3), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset fail_index", 32'(fail_index), 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      load_msg(vecs[v].pos, vecs[v].val);
      run_check($sformatf("vec%0d", v), 1'b0, vecs[v].found, vecs[v].fidx,
                vecs[v].fedge, 0);
    end

    // Hold start high for 10 cycles in DONE, then release and restart.
    load_msg(10, 8'h2E);
    run_check("hold_bad10", 1'b0, 1'b0, 5'd10, 33, 10);
    load_msg(MSG_LEN, 8'h00);
    run_check("restart_clean", 1'b0, 1'b1, 5'd0, 96, 0);

    // Dropping start mid-check must not abort the check.
    load_msg(20, 8'h5A);
    @(negedge clk);
    start_Task3 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_Task3 = 1'b0;
    begin
      int t;
      t = 0;
      while (!finish_Task3 && t < BUDGET) begin
        @(negedge clk);
        t++;
      end
    end
    check("drop_mid finish", 32'(finish_Task3), 32'd1);
    check("drop_mid fail_index", 32'(fail_index), 32'd20);
    @(negedge clk);
    check("drop_mid auto_release", 32'(finish_Task3), 32'd0);

    // Asynchronous reset at edge 40 of a clean check.
    load_msg(MSG_LEN, 8'h00);
    @(negedge clk);
    start_Task3 = 1'b1;
    repeat (41) @(posedge clk);  // edges 0..40
    #2;
    reset = 1'b0;
    #1;
    check("async_rst finish", 32'(finish_Task3), 32'd0);
    check("async_rst key_found", 32'(key_found_Task3), 32'd0);
    check("async_rst rd_addr", 32'(rd_addr), 32'd0);
    check("async_rst fail_index", 32'(fail_index), 32'd0);
    check("async_rst state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;  // start is still high, so the next edge accepts it
    run_check("after_rst", 1'b1, 1'b1, 5'd0, 96, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
